multicycle_controller: RTL and testbench

//  Multi-cycle control FSM for the non-pipelined MIPS core. Sequences instruction fetch from

---
 rtl/multicycle_controller_pkg.sv | 39 +++
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller_wait_counter.sv | 37 +++
 rtl/multicycle_controller.sv | 176 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes,
// FSM state encodings, and datapath select encodings.
package mips_pkg;

  // Supported instruction opcodes (instruction[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // Controller state encodings (also exported on the debug state port)
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  // PC source select
  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  // ALU operation select
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  // True for opcodes that proceed from DECODE into EXEC
  function automatic logic op_needs_exec(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
           (op == OP_SW)    || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. master is the controller's view,
// slave is the datapath/instruction-memory side.
interface multicycle_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic             run;
  logic [5:0]       opcode;
  logic             alu_zero;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             mem_read;
  logic             mem_write;
  logic             alu_src_b;
  logic [1:0]       alu_op;
  logic [2:0]       state;
  logic             halted;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  modport master (
    input  run, opcode, alu_zero,
    output pc_write, pc_src, ir_write, reg_write, reg_dst, mem_to_reg,
           mem_read, mem_write, alu_src_b, alu_op, state, halted,
           illegal_op, retired
  );

  modport slave (
    output run, opcode, alu_zero,
    input  pc_write, pc_src, ir_write, reg_write, reg_dst, mem_to_reg,
           mem_read, mem_write, alu_src_b, alu_op, state, halted,
           illegal_op, retired
  );
endinterface

// File: rtl/multicycle_controller_wait_counter.sv
// Down-counter used to stretch FETCH and MEM over their memory latencies.
// done_o is high while the count is zero; load_i wins over counting.
module ctrl_wait_counter #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: reload, or decrement until zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM for the non-pipelined MIPS core. One instruction
// in flight: FETCH -> DECODE -> EXEC -> MEM -> WB, with early retirement
// for j (DECODE), beq (EXEC) and sw (MEM).
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_LAT = 1,
  parameter int unsigned DMEM_LAT = 1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  localparam int unsigned MAXLAT = (IMEM_LAT > DMEM_LAT) ? IMEM_LAT : DMEM_LAT;
  localparam int unsigned CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  logic [2:0]       state_q, state_d;
  logic [5:0]       ir_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  logic             wait_done;
  logic             wait_load;
  logic [CW-1:0]    wait_val;

  logic             retire;
  logic             set_illegal;
  logic             pc_write;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             reg_write;
  logic             reg_dst;
  logic             mem_to_reg;
  logic             mem_read;
  logic             mem_write;
  logic             alu_src_b;
  logic [1:0]       alu_op;

  ctrl_wait_counter #(
    .W (CW)
  ) u_wait (
    .clk        (clk),
    .rst        (reset),
    .load_i     (wait_load),
    .load_val_i (wait_val),
    .done_o     (wait_done)
  );

  // Next-state and datapath control decode from state and latched opcode
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    pc_src      = PC_SRC_SEQ;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    alu_src_b   = 1'b0;
    alu_op      = ALU_ADD;
    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (wait_done) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q == OP_J) begin
          pc_src = PC_SRC_JUMP;
          retire = 1'b1;
        end else if (ir_q == OP_HALT) begin
          state_d = S_HALT;
        end else if (op_needs_exec(ir_q)) begin
          state_d = S_EXEC;
        end else begin
          set_illegal = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_EXEC: begin
        case (ir_q)
          OP_RTYPE: begin
            alu_op  = ALU_FUNCT;
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_src_b = 1'b1;
            state_d   = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_b = 1'b1;
            state_d   = S_MEM;
          end
          OP_BEQ: begin
            alu_op = ALU_SUB;
            pc_src = bus.alu_zero ? PC_SRC_BRANCH : PC_SRC_SEQ;
            retire = 1'b1;
          end
          default: begin
            set_illegal = 1'b1;
            state_d     = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        mem_read  = (ir_q == OP_LW);
        mem_write = (ir_q == OP_SW);
        if (wait_done) begin
          if (ir_q == OP_SW) retire = 1'b1;
          else               state_d = S_WB;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (ir_q == OP_RTYPE);
        mem_to_reg = (ir_q == OP_LW);
        retire     = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Every retiring cycle carries the instruction's single PC write
    pc_write = retire;
    if (retire) state_d = bus.run ? S_FETCH : S_IDLE;
  end

  // Wait counter is armed on entry to FETCH or MEM with latency-1
  always_comb begin
    wait_load = ((state_d == S_FETCH) && (state_q != S_FETCH)) ||
                ((state_d == S_MEM)   && (state_q != S_MEM));
    wait_val  = (state_d == S_FETCH) ? CW'(IMEM_LAT - 1) : CW'(DMEM_LAT - 1);
  end

  // State, instruction opcode, sticky illegal flag and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_write)    ir_q      <= bus.opcode;
      if (set_illegal) illegal_q <= 1'b1;
      if (retire)      retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.pc_src     = pc_src;
  assign bus.ir_write   = ir_write;
  assign bus.reg_write  = reg_write;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.mem_read   = mem_read;
  assign bus.mem_write  = mem_write;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.alu_op     = alu_op;
  assign bus.state      = state_q;
  assign bus.halted     = (state_q == S_HALT);
  assign bus.illegal_op = illegal_q;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a per-cycle expected
// control trace is built from the instruction-level timing rules and
// compared against two DUTs (latencies 1/1 and 3/2 with a 3-bit counter).
module tb_multicycle_controller;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_controller_if #(.CNT_W(32)) bus_a ();
  multicycle_controller_if #(.CNT_W(3))  bus_b ();

  multicycle_controller #(.IMEM_LAT(1), .DMEM_LAT(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.master)
  );
  multicycle_controller #(.IMEM_LAT(3), .DMEM_LAT(2), .CNT_W(3)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.master)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       rw;
    logic       rd;
    logic       m2r;
    logic       mr;
    logic       mw;
    logic       asb;
    logic [1:0] aop;
    logic       hlt;
    logic       ill;
  } cyc_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cnt_a = 0;
  int unsigned cnt_b = 0;
  cyc_t exp_q[$];

  function automatic cyc_t blank(input logic [2:0] s);
    cyc_t c;
    c = '0;
    c.st = s;
    return c;
  endfunction

  // Expected cycle-by-cycle outputs for one instruction, FETCH through retire
  function automatic void build(input logic [5:0] op, input logic z,
                                input int ilat, input int dlat);
    cyc_t c;
    exp_q.delete();
    for (int i = 0; i < ilat; i++) begin
      c = blank(S_FETCH);
      c.irw = (i == ilat - 1);
      exp_q.push_back(c);
    end
    c = blank(S_DECODE);
    if (op == 6'h02) begin
      c.pcw = 1'b1;
      c.pcs = 2'd2;
      exp_q.push_back(c);
      return;
    end
    exp_q.push_back(c);
    if (!(op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04})) begin
      c = blank(S_HALT);
      c.hlt = 1'b1;
      c.ill = (op != 6'h3F);
      exp_q.push_back(c);
      return;
    end
    c = blank(S_EXEC);
    if (op == 6'h00) c.aop = 2'd2;
    else if (op == 6'h04) begin
      c.aop = 2'd1;
      c.pcw = 1'b1;
      c.pcs = z ? 2'd1 : 2'd0;
    end else c.asb = 1'b1;
    exp_q.push_back(c);
    if (op == 6'h04) return;
    if (op == 6'h23 || op == 6'h2B) begin
      for (int i = 0; i < dlat; i++) begin
        c = blank(S_MEM);
        c.mr  = (op == 6'h23);
        c.mw  = (op == 6'h2B);
        c.pcw = (op == 6'h2B) && (i == dlat - 1);
        exp_q.push_back(c);
      end
    end
    if (op == 6'h2B) return;
    c = blank(S_WB);
    c.rw  = 1'b1;
    c.rd  = (op == 6'h00);
    c.m2r = (op == 6'h23);
    c.pcw = 1'b1;
    exp_q.push_back(c);
  endfunction

  function automatic cyc_t sample(input bit sel);
    cyc_t c;
    if (sel) begin
      c.st = bus_b.state;   c.pcw = bus_b.pc_write;  c.pcs = bus_b.pc_src;
      c.irw = bus_b.ir_write; c.rw = bus_b.reg_write; c.rd = bus_b.reg_dst;
      c.m2r = bus_b.mem_to_reg; c.mr = bus_b.mem_read; c.mw = bus_b.mem_write;
      c.asb = bus_b.alu_src_b; c.aop = bus_b.alu_op; c.hlt = bus_b.halted;
      c.ill = bus_b.illegal_op;
    end else begin
      c.st = bus_a.state;   c.pcw = bus_a.pc_write;  c.pcs = bus_a.pc_src;
      c.irw = bus_a.ir_write; c.rw = bus_a.reg_write; c.rd = bus_a.reg_dst;
      c.m2r = bus_a.mem_to_reg; c.mr = bus_a.mem_read; c.mw = bus_a.mem_write;
      c.asb = bus_a.alu_src_b; c.aop = bus_a.alu_op; c.hlt = bus_a.halted;
      c.ill = bus_a.illegal_op;
    end
    return c;
  endfunction

  function automatic logic [31:0] ret_of(input bit sel);
    return sel ? 32'(bus_b.retired) : bus_a.retired;
  endfunction

  function automatic logic [31:0] model_cnt(input bit sel);
    return sel ? 32'(cnt_b % 8) : 32'(cnt_a);
  endfunction

  // Present one instruction and check every cycle of its expected trace
  task automatic run_instr(input bit sel, input logic [5:0] op, input logic z,
                           input int limit, input int drop_at, input string tag);
    cyc_t e, act;
    logic [5:0] opd;
    logic zd;
    build(op, z, sel ? 3 : 1, sel ? 2 : 1);
    for (int k = 0; k < exp_q.size() && k < limit; k++) begin
      e = exp_q[k];
      @(negedge clk);
      if (k == drop_at) begin
        if (sel) bus_b.run = 1'b0; else bus_a.run = 1'b0;
      end
      opd = e.irw ? op : 6'($urandom);
      zd  = (e.st == S_EXEC) ? z : 1'($urandom);
      if (sel) begin bus_b.opcode = opd; bus_b.alu_zero = zd; end
      else     begin bus_a.opcode = opd; bus_a.alu_zero = zd; end
      #1;
      act = sample(sel);
      n_checks++;
      if (act !== e) begin
        n_errors++;
        $display("FAIL %s[%0d] op=%h outputs: got %b expected %b (state got %0d exp %0d)",
                 tag, k, op, act, e, act.st, e.st);
      end
      n_checks++;
      if (ret_of(sel) !== model_cnt(sel)) begin
        n_errors++;
        $display("FAIL %s[%0d] retired: got %0d expected %0d", tag, k, ret_of(sel), model_cnt(sel));
      end
      if (e.pcw) begin
        if (sel) cnt_b++; else cnt_a++;
      end
    end
  endtask

  // Hold a fixed expected output vector for n cycles
  task automatic hold_check(input bit sel, input cyc_t e, input int n, input string tag);
    cyc_t act;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (sel) bus_b.opcode = 6'($urandom); else bus_a.opcode = 6'($urandom);
      #1;
      act = sample(sel);
      n_checks++;
      if (act !== e || ret_of(sel) !== model_cnt(sel)) begin
        n_errors++;
        $display("FAIL %s[%0d]: got %b retired %0d expected %b retired %0d",
                 tag, k, act, ret_of(sel), e, model_cnt(sel));
      end
    end
  endtask

  // Assert reset for two cycles (checking both DUTs cleared), release on a negedge
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      for (int s = 0; s < 2; s++) begin
        n_checks++;
        if (sample(s[0]) !== blank(S_IDLE) || ret_of(s[0]) !== 32'd0) begin
          n_errors++;
          $display("FAIL %s dut%0d: got %b retired %0d expected %b retired 0",
                   tag, s, sample(s[0]), ret_of(s[0]), blank(S_IDLE));
        end
      end
      @(negedge clk);
    end
    reset = 1'b0;
    cnt_a = 0;
    cnt_b = 0;
  endtask

  task automatic test_reset();
    bus_a.run = 1'b1;
    do_reset("reset_with_run");
  endtask

  task automatic test_lw();
    run_instr(0, 6'h23, 1'($urandom), 99, -1, "lw");
  endtask

  task automatic test_beq();
    run_instr(0, 6'h04, 1'b1, 99, -1, "beq_taken");
    run_instr(0, 6'h04, 1'b0, 99, -1, "beq_not_taken");
  endtask

  task automatic test_j();
    run_instr(0, 6'h02, 1'($urandom), 99, -1, "j");
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    for (int i = 0; i < 40; i++)
      run_instr(0, ops[$urandom_range(0, 5)], 1'($urandom), 99, -1, "random");
  endtask

  task automatic test_run_drop();
    run_instr(0, 6'h00, 1'($urandom), 99, 1, "rtype_run_drop");
    hold_check(0, blank(S_IDLE), 4, "idle_after_drop");
  endtask

  task automatic test_latency();
    logic [5:0] ops [6];
    ops = '{6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02};
    @(negedge clk);
    bus_b.run = 1'b1;
    run_instr(1, 6'h2B, 1'($urandom), 99, -1, "sw_lat32");
    for (int i = 0; i < 11; i++)
      run_instr(1, ops[$urandom_range(0, 5)], 1'($urandom), 99, -1, "random_lat32");
    run_instr(1, 6'h23, 1'($urandom), 99, 0, "lw_lat32_last");
    hold_check(1, blank(S_IDLE), 3, "idle_lat32");
  endtask

  task automatic test_illegal();
    cyc_t h;
    @(negedge clk);
    bus_a.run = 1'b1;
    run_instr(0, 6'h3A, 1'($urandom), 99, -1, "illegal");
    h = blank(S_HALT);
    h.hlt = 1'b1;
    h.ill = 1'b1;
    hold_check(0, h, 20, "halt_illegal");
    do_reset("reset_clears_illegal");
    run_instr(0, 6'h3F, 1'($urandom), 99, -1, "halt_op");
    h.ill = 1'b0;
    hold_check(0, h, 5, "halt_legal");
    do_reset("reset_after_halt");
  endtask

  task automatic test_reset_mid();
    run_instr(0, 6'h08, 1'($urandom), 99, -1, "addi_pre");
    run_instr(0, 6'h23, 1'($urandom), 4, -1, "lw_to_mem");
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (sample(0) !== blank(S_IDLE) || ret_of(0) !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_in_mem: got %b retired %0d expected %b retired 0",
               sample(0), ret_of(0), blank(S_IDLE));
    end
    cnt_a = 0;
    @(negedge clk);
    reset = 1'b0;
    run_instr(0, 6'h02, 1'($urandom), 99, 0, "j_after_reset");
    hold_check(0, blank(S_IDLE), 2, "idle_end");
  endtask

  initial begin
    reset = 1'b1;
    bus_a.run = 1'b0; bus_a.opcode = '0; bus_a.alu_zero = 1'b0;
    bus_b.run = 1'b0; bus_b.opcode = '0; bus_b.alu_zero = 1'b0;
    test_reset();
    test_lw();
    test_beq();
    test_j();
    test_random();
    test_run_drop();
    test_latency();
    test_illegal();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
